// File: rtl/delta_demod_decimator.sv
// delta_demod_decimator
// Rebuilds the modulator staircase from the delta bitstream with a
// saturating up/down integrator, box-car averages 2**DEC_LOG2 integrator
// samples and presents one decimated sample per window on a valid/ready
// output. A window result that finds the output still occupied is dropped
// and recorded in a sticky overrun flag.
module delta_demod_decimator #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEC_LOG2 = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_en,
  input  logic             bit_in,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  input  logic             clr_ovr
);

  // Accumulator holds the sum of 2**DEC_LOG2 WIDTH-bit values without overflow.
  localparam int unsigned ACC_W = WIDTH + DEC_LOG2;
  localparam logic [WIDTH-1:0] INTEG_MAX = '1;

  logic [WIDTH-1:0]    integ_reg;
  logic [WIDTH-1:0]    integ_next;
  logic [ACC_W-1:0]    acc_reg;
  logic [ACC_W-1:0]    acc_sum;
  logic [DEC_LOG2-1:0] cnt_reg;
  logic [WIDTH-1:0]    out_data_reg;
  logic                out_valid_reg;
  logic                overrun_reg;
  logic                window_done;
  logic                out_busy;
  logic [WIDTH-1:0]    result;

  // Saturating integrator step; holds when the sample is not qualified.
  always_comb begin
    integ_next = integ_reg;
    if (sample_en) begin
      if (bit_in && (integ_reg != INTEG_MAX)) begin
        integ_next = integ_reg + WIDTH'(1);
      end else if (!bit_in && (integ_reg != '0)) begin
        integ_next = integ_reg - WIDTH'(1);
      end
    end
  end

  // The window sum includes the post-update integrator value of this sample.
  assign acc_sum     = acc_reg + ACC_W'(integ_next);
  assign window_done = sample_en && (cnt_reg == '1);
  // Truncating divide by the window length; always fits in WIDTH bits.
  assign result      = acc_sum[ACC_W-1:DEC_LOG2];
  // Output register is occupied and the consumer is not taking it this cycle.
  assign out_busy    = out_valid_reg && !out_ready;

  // Integrator and window accumulation; only qualified samples advance them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      integ_reg <= '0;
      acc_reg   <= '0;
      cnt_reg   <= '0;
    end else if (sample_en) begin
      integ_reg <= integ_next;
      if (window_done) begin
        acc_reg <= '0;
        cnt_reg <= '0;
      end else begin
        acc_reg <= acc_sum;
        cnt_reg <= cnt_reg + DEC_LOG2'(1);
      end
    end
  end

  // Output holding register with valid/ready handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
    end else if (window_done && !out_busy) begin
      // Either the register was empty or it is being consumed right now.
      out_data_reg  <= result;
      out_valid_reg <= 1'b1;
    end else if (out_valid_reg && out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  // Sticky overrun flag; a simultaneous drop and clear leaves it set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overrun_reg <= 1'b0;
    end else if (window_done && out_busy) begin
      overrun_reg <= 1'b1;
    end else if (clr_ovr) begin
      overrun_reg <= 1'b0;
    end
  end

  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_delta_demod_decimator.sv
// tb_delta_demod_decimator
// Directed scenarios followed by randomized traffic, every cycle compared
// against an arithmetic reference model of the receiver.
module tb_delta_demod_decimator;

  localparam int WIDTH    = 8;
  localparam int DEC_LOG2 = 4;
  localparam int WIN      = 1 << DEC_LOG2;
  localparam int MAXV     = (1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             sample_en = 1'b0;
  logic             bit_in = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             overrun;
  logic             clr_ovr = 1'b0;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_integ = 0;
  int m_samples[$];
  int m_data = 0;
  bit m_valid = 0;
  bit m_ovr = 0;

  // Observed transfers
  int xfer_cnt = 0;
  int last_xfer = -1;

  delta_demod_decimator #(.WIDTH(WIDTH), .DEC_LOG2(DEC_LOG2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sample_en (sample_en),
    .bit_in    (bit_in),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun),
    .clr_ovr   (clr_ovr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Behavioural model: integrator as a clamped integer, windows as a list
  // of samples averaged with integer division.
  function automatic void model_step(input bit r, input bit se, input bit b,
                                     input bit rdy, input bit clr);
    bit done;
    bit drop;
    int res;
    int sum;
    done = 0;
    res  = 0;
    if (!r) begin
      m_integ = 0;
      m_samples.delete();
      m_data  = 0;
      m_valid = 0;
      m_ovr   = 0;
      return;
    end
    if (se) begin
      m_integ = b ? ((m_integ < MAXV) ? m_integ + 1 : MAXV)
                  : ((m_integ > 0) ? m_integ - 1 : 0);
      m_samples.push_back(m_integ);
      if (m_samples.size() == WIN) begin
        sum = 0;
        foreach (m_samples[k]) sum += m_samples[k];
        res  = sum / WIN;
        done = 1;
        m_samples.delete();
      end
    end
    drop = done && m_valid && !rdy;
    if (done && !drop) begin
      m_data  = res;
      m_valid = 1;
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
    if (drop) m_ovr = 1;
    else if (clr) m_ovr = 0;
  endfunction

  // One clock cycle: drive, record any transfer, update model, compare.
  task automatic step(input bit r, input bit se, input bit b,
                      input bit rdy, input bit clr);
    rst_n = r; sample_en = se; bit_in = b; out_ready = rdy; clr_ovr = clr;
    #1;
    if (r && out_valid === 1'b1 && rdy) begin
      xfer_cnt++;
      last_xfer = int'(out_data);
    end
    @(posedge clk);
    model_step(r, se, b, rdy, clr);
    #1;
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("out_data", 32'(out_data), 32'(m_data));
    check("overrun", 32'(overrun), 32'(m_ovr));
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    xfer_cnt = 0;
    last_xfer = -1;
  endtask

  initial begin
    int bias;

    // 1 Reset
    do_reset(2);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_ovr", 32'(overrun), 0);

    // 2 Ramp: 16 ones -> mean of 1..16 = 8, valid for one cycle
    for (int i = 0; i < 15; i++) step(1, 1, 1, 1, 0);
    check("ramp_early_valid", 32'(out_valid), 0);
    step(1, 1, 1, 1, 0);
    check("ramp_valid", 32'(out_valid), 1);
    check("ramp_data", 32'(out_data), 8);
    step(1, 0, 0, 1, 0);
    check("ramp_valid_drop", 32'(out_valid), 0);
    check("ramp_xfers", 32'(xfer_cnt), 1);
    check("ramp_xfer_data", 32'(last_xfer), 8);

    // 3 Saturation up then down
    do_reset(1);
    for (int i = 0; i < 300; i++) step(1, 1, 1, 1, 0);
    step(1, 0, 0, 1, 0);
    check("sat_hi_data", 32'(last_xfer), 255);
    for (int i = 0; i < 300; i++) step(1, 1, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    check("sat_lo_data", 32'(last_xfer), 0);

    // 4 Alternating 1,0 with gap cycles in between
    do_reset(1);
    for (int i = 0; i < 16; i++) begin
      step(1, 1, (i % 2) == 0, 1, 0);
      step(1, 0, $urandom_range(0, 1) == 1, 1, 0);
    end
    step(1, 0, 0, 1, 0);
    check("alt_xfers", 32'(xfer_cnt), 1);
    check("alt_data", 32'(last_xfer), 0);

    // 5 Backpressure over two windows
    do_reset(1);
    for (int i = 0; i < 32; i++) step(1, 1, 1, 0, 0);
    check("bp_valid", 32'(out_valid), 1);
    check("bp_data", 32'(out_data), 8);
    check("bp_ovr", 32'(overrun), 1);
    step(1, 0, 0, 1, 0);
    check("bp_xfer_data", 32'(last_xfer), 8);
    check("bp_valid_after", 32'(out_valid), 0);
    check("bp_ovr_sticky", 32'(overrun), 1);
    step(1, 0, 0, 0, 1);
    check("bp_ovr_clr", 32'(overrun), 0);
    do_reset(1);
    for (int i = 0; i < 31; i++) step(1, 1, 1, 0, 0);
    step(1, 1, 1, 0, 1);
    check("bp_set_wins", 32'(overrun), 1);

    // 6 Mid-window reset discards the partial window
    do_reset(1);
    for (int i = 0; i < 7; i++) step(1, 1, 1, 1, 0);
    do_reset(1);
    for (int i = 0; i < 15; i++) step(1, 1, 1, 1, 0);
    check("mid_early_valid", 32'(out_valid), 0);
    step(1, 1, 1, 1, 0);
    check("mid_valid", 32'(out_valid), 1);
    check("mid_data", 32'(out_data), 8);
    step(1, 0, 0, 1, 0);
    check("mid_xfers", 32'(xfer_cnt), 1);

    // Randomized traffic with drifting bit density
    do_reset(1);
    bias = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 150 == 0) bias = int'($urandom_range(0, 100));
      step(($urandom_range(0, 499) != 0),
           ($urandom_range(0, 3) != 0),
           (int'($urandom_range(0, 99)) < bias),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 19) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
